// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, imem req/ack fetch,
// decode-field fan-out and next-PC commit on exec_done.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        PCSel,
    input  logic [31:0] ALU_Result,
    input  logic        exec_done,
    output logic        halted,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_req;
    logic        r_halted;
    logic        r_misaligned;
    logic        r_bus_err;
    logic [31:0] r_retired;
    logic [7:0]  r_wait;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;
    // jalr rule: bit 0 of the target is always dropped
    assign w_target   = ALU_Result & ~32'h1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_req        <= 1'b0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            r_retired    <= 32'h0;
            r_wait       <= 8'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    r_wait  <= 8'h0;
                end
                FETCH: begin
                    // an ack on the timeout cycle still wins
                    if (imem_ack) begin
                        r_inst       <= imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_req        <= 1'b0;
                        r_wait       <= 8'h0;
                        r_state      <= EXEC;
                    end else if (r_wait == WAIT_LIM) begin
                        r_req     <= 1'b0;
                        r_inst    <= 32'h0;
                        r_halted  <= 1'b1;
                        r_bus_err <= 1'b1;
                        r_wait    <= 8'h0;
                        r_state   <= HALT;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (PCSel && w_target[1]) begin
                            r_inst       <= 32'h0;
                            r_inst_valid <= 1'b0;
                            r_halted     <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_state      <= HALT;
                        end else begin
                            r_pc         <= PCSel ? w_target : w_pc_plus4;
                            r_inst_valid <= 1'b0;
                            r_retired    <= r_retired + 32'd1;
                            r_req        <= 1'b1;
                            r_wait       <= 8'h0;
                            r_state      <= FETCH;
                        end
                    end
                end
                HALT: begin
                    r_req        <= 1'b0;
                    r_inst       <= 32'h0;
                    r_inst_valid <= 1'b0;
                    r_halted     <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign opcode     = r_inst[6:0];
    assign funct3     = r_inst[14:12];
    assign funct7     = r_inst[30];
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign halted     = r_halted;
    assign misaligned = r_misaligned;
    assign bus_err    = r_bus_err;
    assign retired    = r_retired;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch front end for the single-issue RV32 subset core. Holds the PC and fetches one word per instruction from instruction memory over a req/ack handshake. Presents the instruction and its decode fields (opcode, funct3, funct7 bit) to the control unit. Commits the next PC from the control unit's PCSel and the ALU target once the datapath signals completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in FETCH waiting for imem_ack before bus error (2..255)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request, registered
imem_addr  output  32  fetch address, equals pc
imem_ack  input  1  memory response valid; ignored when imem_req=0
imem_rdata  input  32  instruction word, sampled on the edge where imem_req&imem_ack
inst  output  32  held instruction word
opcode  output  7  inst[6:0]
funct3  output  3  inst[14:12]
funct7  output  1  inst[30]
inst_valid  output  1  inst is valid for execution
pc  output  32  address of inst
pc_plus4  output  32  pc+4 mod 2^32, combinational
PCSel  input  1  from control unit: 1 = take ALU target
ALU_Result  input  32  jump/branch target from ALU
exec_done  input  1  datapath finished current instruction; sampled only in EXEC
halted  output  1  fetch stopped, sticky until rst
misaligned  output  1  halt cause: target not word aligned
bus_err  output  1  halt cause: imem_ack timeout
retired  output  32  count of accepted exec_done, wraps

Behaviour:
- Reset (async, any state, mid-handshake included):
  - pc=RESET_PC, inst=0, inst_valid=0, imem_req=0.
  - halted=0, misaligned=0, bus_err=0, retired=0, wait counter=0, state=IDLE.
  - A pending ack is abandoned.
- inst=0 decodes as opcode 0, so the control unit outputs all-zero controls: no register or memory writes.
- States IDLE, FETCH, EXEC, HALT.
- IDLE: on the first clock after rst deasserts, go to FETCH with imem_req=1.
- FETCH:
  - imem_req held 1 and imem_addr stable until ack.
  - On imem_req&imem_ack: inst<=imem_rdata, inst_valid<=1, imem_req<=0, go to EXEC.
  - Wait counter increments each FETCH cycle without ack. If ack is still absent when the counter reaches TIMEOUT-1, go to HALT with bus_err=1.
  - Ack in the same cycle as the timeout wins: instruction accepted, no error.
- EXEC:
  - inst and pc are held while waiting for exec_done.
  - On exec_done with PCSel=0: pc<=pc+4.
  - On exec_done with PCSel=1: target = {ALU_Result[31:1],1'b0} (bit0 cleared, jalr rule).
    - If target[1]=1: go to HALT with misaligned=1, and pc is not updated.
    - Otherwise pc<=target.
  - Non-halt exec_done: inst_valid<=0, retired<=retired+1, imem_req<=1, go to FETCH.
  - The misaligned halt does not increment retired.
- exec_done is ignored outside EXEC. PCSel and ALU_Result are ignored except on the exec_done edge.
- HALT:
  - imem_req=0, inst_valid=0, inst<=0, halted=1.
  - Exit only by rst. Only one cause flag can be set.
- Best-case latency: exec_done edge → imem_req high the next cycle → ack in that cycle → inst_valid the following cycle. That is 2 cycles per instruction with a zero-wait memory.
- pc wrap: 32'hFFFF_FFFC + 4 = 0, no error.

Test Plan:
- Reset then straight-line code: RESET_PC=0, memory acks immediately, 3× exec_done with PCSel=0 → imem_addr sequence 0,4,8,C; retired=3; opcode/funct3/funct7 match the fetched word (e.g. 32'h40B50533 gives opcode 0110011, funct3 000, funct7 1).
- Jump: exec_done with PCSel=1, ALU_Result=32'h0000_0101 → next imem_addr=32'h100 (bit0 cleared), no halt.
- Misaligned jump: PCSel=1, ALU_Result=32'h0000_0102 → halted=1, misaligned=1, inst=0, pc unchanged, imem_req stays 0.
- Wait states and timeout: ack after 5 cycles → accepted, inst_valid=1. With no ack and TIMEOUT=16 → bus_err=1 and halted=1 exactly 16 cycles after imem_req rises. Ack in the 16th cycle → accepted, no error.
- Async reset mid-FETCH with imem_req=1 → outputs reset immediately, before any clock edge. A following ack is ignored; fetch restarts at RESET_PC one cycle after rst release.
- Spurious inputs: imem_ack while imem_req=0, or exec_done in FETCH → no state change, retired unchanged.
